// File: rtl/vga_pattern_sequencer.sv
// VGA test-pattern source for the 640x480 path.
// Four patterns, advanced on frame boundaries (auto or manual).
module vga_pattern_sequencer #(
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int H_ACTIVE           = 640,
  parameter int V_ACTIVE           = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_addr,
  input  logic [9:0]  v_addr,
  input  logic        valid,
  input  logic        mode_auto,
  input  logic        next_req,
  output logic [23:0] data,
  output logic [1:0]  pattern_id,
  output logic        frame_end
);

  localparam int CW =
    (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRAMES_PER_PATTERN - 1);
  localparam logic [9:0]    H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    V_LAST   = 10'(V_ACTIVE - 1);

  typedef enum logic {
    S_AUTO,
    S_MANUAL
  } state_t;

  state_t        state_q, state_d;
  logic [23:0]   data_q, data_d;
  logic [1:0]    pattern_id_q, pattern_id_d;
  logic          frame_end_q, frame_end_d;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic          pending_q, pending_d;
  logic          advance;
  logic          eof;

  assign eof = valid && (h_addr == H_LAST) && (v_addr == V_LAST);

  function automatic logic [2:0] band(
    input logic [9:0] a,
    input logic [9:0] t0,
    input logic [9:0] t1,
    input logic [9:0] t2,
    input logic [9:0] t3,
    input logic [9:0] t4
  );
    logic [2:0] b;
    if (a < t0)      b = 3'd0;
    else if (a < t1) b = 3'd1;
    else if (a < t2) b = 3'd2;
    else if (a < t3) b = 3'd3;
    else if (a < t4) b = 3'd4;
    else             b = 3'd5;
    return b;
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [2:0] b);
    logic [23:0] c;
    unique case (b)
      3'd0:    c = 24'hFF0000;
      3'd1:    c = 24'hFFFF00;
      3'd2:    c = 24'h00FF00;
      3'd3:    c = 24'h00FFFF;
      3'd4:    c = 24'h0000FF;
      default: c = 24'hFF00FF;
    endcase
    return c;
  endfunction

  function automatic logic [23:0] pat(
    input logic [1:0] id,
    input logic [9:0] h,
    input logic [9:0] v
  );
    logic [23:0] c;
    unique case (id)
      2'd0: c = bar_rgb(band(h, 10'd107, 10'd214, 10'd321,
                             10'd428, 10'd535));
      2'd1: c = bar_rgb(band(v, 10'd80, 10'd160, 10'd240,
                             10'd320, 10'd400));
      2'd2: c = (h[5] ^ v[5]) ? 24'hFFFFFF : 24'h000000;
      default: c = {h[9:2], v[8:1], 8'h80};
    endcase
    return c;
  endfunction

  // Next-state: pixel data, frame pulse and pattern scheduling.
  always_comb begin
    state_d      = mode_auto ? S_AUTO : S_MANUAL;
    data_d       = valid ? pat(pattern_id_q, h_addr, v_addr) : 24'h0;
    frame_end_d  = eof;
    frame_cnt_d  = frame_cnt_q;
    pending_d    = pending_q;
    pattern_id_d = pattern_id_q;
    advance      = 1'b0;
    unique case (state_q)
      S_AUTO: begin
        pending_d = 1'b0;
        if (eof) begin
          if (frame_cnt_q == CNT_LAST) begin
            frame_cnt_d = '0;
            advance     = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        frame_cnt_d = '0;
        if (eof && (pending_q || next_req)) begin
          advance   = 1'b1;
          pending_d = 1'b0;
        end else if (next_req) begin
          pending_d = 1'b1;
        end
      end
    endcase
    if (advance) pattern_id_d = pattern_id_q + 2'd1;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_AUTO;
      data_q       <= '0;
      pattern_id_q <= '0;
      frame_end_q  <= 1'b0;
      frame_cnt_q  <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      pattern_id_q <= pattern_id_d;
      frame_end_q  <= frame_end_d;
      frame_cnt_q  <= frame_cnt_d;
      pending_q    <= pending_d;
    end
  end

  assign data       = data_q;
  assign pattern_id = pattern_id_q;
  assign frame_end  = frame_end_q;

endmodule
